stft_sample_scheduler: RTL and testbench
========================================

Name: stft_sample_scheduler

Overview:
- Front-end sequencer for the sliding-DFT bin-update engine.
- Accepts one audio sample strobe at a time and manages the FFT_SIZE-deep sample ring buffer: it reads the oldest sample, then overwrites it with the new one.
- Hands the difference (new minus oldest) to the engine with a start pulse and waits for the engine to finish all bins.
- Every DISP_PERIOD samples, requests a display snapshot through a req/ack handshake.

Parameters:
- WORD_WIDTH, 16: sample and difference width, two's complement.
- FFT_SIZE, 512: ring buffer depth and bin count; must be a power of two.
- DISP_PERIOD, 4410: number of processed samples between display requests; must be at least 1.

Ports:
- clk  in  1: system clock, rising edge.
- reset  in  1: asynchronous, active-high reset.
- s_valid  in  1: new-sample strobe; the source cannot stall.
- s_data  in  WORD_WIDTH: new sample value.
- s_ready  out  1: high only in IDLE.
- rb_addr  out  $clog2(FFT_SIZE): ring buffer address.
- rb_rd_en  out  1: ring buffer read enable; read data is valid one cycle later.
- rb_rdata  in  WORD_WIDTH: ring buffer read data.
- rb_wr_en  out  1: ring buffer write enable.
- rb_wdata  out  WORD_WIDTH: ring buffer write data.
- eng_start  out  1: one-cycle pulse that starts a bin-update pass.
- eng_diff  out  WORD_WIDTH: sample difference for the engine; held stable until the next accept.
- eng_done  in  1: pulse from the engine after its last bin is written.
- disp_req  out  1: display snapshot request, level.
- disp_ack  in  1: display snapshot acknowledge.
- ovr_clr  in  1: synchronous clear of overrun.
- overrun  out  1: sticky; a sample was dropped.
- busy  out  1: high whenever the state is not IDLE.

Behaviour:
- All outputs are registered. Reset (async, active-high) applies:
  - state=IDLE;
  - wr_ptr=0, fill_cnt=0, disp_cnt=0;
  - every output 0, except s_ready=1.
- Asserting reset mid-operation aborts the current pass at once, without drain or display request. The RAM contents are not cleared.
- States: IDLE, RD, WR, START, BUSY, DISP.
- IDLE:
  - s_ready=1.
  - When s_valid=1, latch s_data into hold and go to RD.
- RD (1 cycle):
  - rb_addr=wr_ptr, rb_rd_en=1, go to WR.
- WR (1 cycle):
  - rb_rdata is valid this cycle.
  - rb_addr=wr_ptr, rb_wr_en=1, rb_wdata=hold.
  - Register eng_diff = hold - old, wrapping modulo 2^WORD_WIDTH with no saturation.
  - old = 0 while fill_cnt < FFT_SIZE (warm-up: the RAM is uninitialised); otherwise old = rb_rdata.
  - Go to START.
- START (1 cycle):
  - eng_start=1, go to BUSY.
- BUSY:
  - Wait for eng_done.
  - On eng_done:
    - wr_ptr increments and wraps from FFT_SIZE-1 to 0;
    - fill_cnt increments and saturates at FFT_SIZE;
    - if disp_cnt == DISP_PERIOD-1, set disp_cnt=0 and go to DISP; otherwise disp_cnt increments and the state goes to IDLE.
- DISP:
  - disp_req=1. When disp_ack=1, drop disp_req in the next cycle and go to IDLE.
  - disp_ack may arrive in the same cycle disp_req first rises is observed; it takes effect on that edge.
- Latency: accept edge to eng_start high is 3 cycles. Minimum sample period is 5 cycles plus the engine pass, plus the handshake on display periods.
- Overrun: s_valid=1 in any state other than IDLE sets overrun and drops the sample. The sample is not queued, and wr_ptr, fill_cnt and disp_cnt are unchanged.
  - ovr_clr clears overrun. If ovr_clr and a new drop coincide, the flag stays set (set wins).
- Stray inputs:
  - eng_done outside BUSY is ignored.
  - disp_ack outside DISP is ignored.
  - eng_done arriving in START (same cycle as eng_start) is ignored; the engine must finish in BUSY.
- DISP_PERIOD=1 means every sample requests a display.

Decomposition:
- Shared package stft_pkg:
  - state encoding for the six states;
  - default FFT_SIZE, WORD_WIDTH and DISP_PERIOD;
  - localparam ADDR_W=$clog2(FFT_SIZE).
- One natural sub-module: stft_period_counter. It holds the disp_cnt compare and wrap, with an increment input and a terminal-count output, and is reusable for other frame-rate dividers.
- The ring buffer RAM stays external.

Test Plan:
All scenarios use FFT_SIZE=8 and DISP_PERIOD=3, with an engine model that pulses eng_done 4 cycles after eng_start.
- Reset then first sample s_data=0x0010 -> rb_wr_en at addr 0 with wdata 0x0010; eng_diff=0x0010 (warm-up ignores rb_rdata=0xDEAD); eng_start exactly 3 cycles after the accept edge.
- Write samples 1..8, then sample 9=0x0005 -> read and write at addr 0; eng_diff=0x0004; wr_ptr wraps 7->0.
- Samples with new=0x8000, old=0x7FFF (post warm-up) -> eng_diff=0x0001 (modulo wrap); new=0x0000, old=0x0001 -> eng_diff=0xFFFF.
- Three samples with disp_ack tied low -> after the third eng_done, disp_req stays high and s_ready=0; disp_ack pulsed 10 cycles later -> disp_req falls next cycle and IDLE resumes; the 6th sample requests again.
- s_valid strobed during BUSY -> overrun=1, wr_ptr unchanged, no extra eng_start; ovr_clr together with another drop -> overrun stays 1; ovr_clr alone -> 0.
- reset asserted in BUSY mid-pass, and again in DISP -> outputs drop asynchronously to reset values; the next sample writes addr 0 with warm-up diff = sample value.

Source files
------------

// File: rtl/stft_pkg.sv
// Shared state encoding and default sizing for the sliding-DFT sample scheduler.
package stft_pkg;

  localparam int DEF_WORD_WIDTH  = 16;
  localparam int DEF_FFT_SIZE    = 512;
  localparam int DEF_DISP_PERIOD = 4410;
  localparam int ADDR_W          = $clog2(DEF_FFT_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_START = 3'd3,
    ST_BUSY  = 3'd4,
    ST_DISP  = 3'd5
  } state_t;

endpackage

// File: rtl/stft_sample_scheduler_if.sv
// Sample stream, ring-buffer, engine and display signals of the sample scheduler.
interface stft_sample_scheduler_if
  import stft_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int FFT_SIZE   = DEF_FFT_SIZE
);

  logic                          s_valid;
  logic [WORD_WIDTH-1:0]         s_data;
  logic                          s_ready;
  logic [$clog2(FFT_SIZE)-1:0]   rb_addr;
  logic                          rb_rd_en;
  logic [WORD_WIDTH-1:0]         rb_rdata;
  logic                          rb_wr_en;
  logic [WORD_WIDTH-1:0]         rb_wdata;
  logic                          eng_start;
  logic [WORD_WIDTH-1:0]         eng_diff;
  logic                          eng_done;
  logic                          disp_req;
  logic                          disp_ack;
  logic                          ovr_clr;
  logic                          overrun;
  logic                          busy;

  // The scheduler is the master; source, RAM, engine and display form the slave side.
  modport master (
    input  s_valid, s_data, rb_rdata, eng_done, disp_ack, ovr_clr,
    output s_ready, rb_addr, rb_rd_en, rb_wr_en, rb_wdata,
           eng_start, eng_diff, disp_req, overrun, busy
  );

  modport slave (
    output s_valid, s_data, rb_rdata, eng_done, disp_ack, ovr_clr,
    input  s_ready, rb_addr, rb_rd_en, rb_wr_en, rb_wdata,
           eng_start, eng_diff, disp_req, overrun, busy
  );

endinterface

// File: rtl/stft_period_counter.sv
// Modulo-PERIOD event divider: counts inc pulses and flags the last count of each period.
module stft_period_counter #(
  parameter int PERIOD = 4410
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  output logic tc
);

  localparam int               CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stft_sample_scheduler.sv
// Sequencer feeding the sliding-DFT engine: ring-buffer read/overwrite, difference
// hand-off, engine wait and periodic display snapshot request.
module stft_sample_scheduler
  import stft_pkg::*;
#(
  parameter int WORD_WIDTH  = DEF_WORD_WIDTH,
  parameter int FFT_SIZE    = DEF_FFT_SIZE,
  parameter int DISP_PERIOD = DEF_DISP_PERIOD
) (
  input logic                     clk,
  input logic                     reset,
  stft_sample_scheduler_if.master bus
);

  localparam int                RB_AW    = $clog2(FFT_SIZE);
  localparam int                FILL_W   = RB_AW + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(FFT_SIZE);

  state_t                state, next_state;
  logic [WORD_WIDTH-1:0] hold;
  logic [RB_AW-1:0]      wr_ptr;
  logic [FILL_W-1:0]     fill_cnt;
  logic                  accept, pass_done, drop, warm_up, disp_tc;
  logic [WORD_WIDTH-1:0] old_sample;

  logic                  s_ready_d, busy_d, rb_rd_en_d, rb_wr_en_d, eng_start_d, disp_req_d;
  logic [RB_AW-1:0]      rb_addr_d;
  logic [WORD_WIDTH-1:0] rb_wdata_d;

  assign accept     = (state == ST_IDLE) && bus.s_valid;
  assign drop       = (state != ST_IDLE) && bus.s_valid;
  assign pass_done  = (state == ST_BUSY) && bus.eng_done;
  // The RAM is never cleared, so slots not yet written this run count as zero.
  assign warm_up    = (fill_cnt < FILL_MAX);
  assign old_sample = warm_up ? '0 : bus.rb_rdata;

  stft_period_counter #(
    .PERIOD (DISP_PERIOD)
  ) u_disp_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pass_done),
    .tc    (disp_tc)
  );

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.s_valid) next_state = ST_RD;
      ST_RD:    next_state = ST_WR;
      ST_WR:    next_state = ST_START;
      ST_START: next_state = ST_BUSY;
      ST_BUSY:  if (bus.eng_done) next_state = disp_tc ? ST_DISP : ST_IDLE;
      ST_DISP:  if (bus.disp_ack) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered, so they line up with the state they describe.
  always_comb begin
    s_ready_d   = (next_state == ST_IDLE);
    busy_d      = (next_state != ST_IDLE);
    rb_rd_en_d  = (next_state == ST_RD);
    rb_wr_en_d  = (next_state == ST_WR);
    eng_start_d = (next_state == ST_START);
    disp_req_d  = (next_state == ST_DISP);
    rb_addr_d   = (rb_rd_en_d || rb_wr_en_d) ? wr_ptr : '0;
    rb_wdata_d  = rb_wr_en_d ? hold : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.s_ready   <= 1'b1;
      bus.busy      <= 1'b0;
      bus.rb_rd_en  <= 1'b0;
      bus.rb_wr_en  <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.disp_req  <= 1'b0;
      bus.rb_addr   <= '0;
      bus.rb_wdata  <= '0;
    end else begin
      bus.s_ready   <= s_ready_d;
      bus.busy      <= busy_d;
      bus.rb_rd_en  <= rb_rd_en_d;
      bus.rb_wr_en  <= rb_wr_en_d;
      bus.eng_start <= eng_start_d;
      bus.disp_req  <= disp_req_d;
      bus.rb_addr   <= rb_addr_d;
      bus.rb_wdata  <= rb_wdata_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold         <= '0;
      bus.eng_diff <= '0;
      wr_ptr       <= '0;
      fill_cnt     <= '0;
      bus.overrun  <= 1'b0;
    end else begin
      if (accept) begin
        hold <= bus.s_data;
      end
      // Plain modular subtraction: the engine expects the wrapped difference, not a saturated one.
      if (state == ST_WR) begin
        bus.eng_diff <= hold - old_sample;
      end
      if (pass_done) begin
        wr_ptr <= wr_ptr + RB_AW'(1);
        if (warm_up) begin
          fill_cnt <= fill_cnt + FILL_W'(1);
        end
      end
      if (drop) begin
        bus.overrun <= 1'b1;
      end else if (bus.ovr_clr) begin
        bus.overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stft_sample_scheduler.sv
// Directed bench for stft_sample_scheduler with a ring-buffer RAM model, a fixed-latency
// engine model and a scoreboard of expected write/difference results.
module tb_stft_sample_scheduler;

  localparam int WW = 16;
  localparam int FS = 8;
  localparam int DP = 3;
  localparam int AW = $clog2(FS);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic [WW-1:0] diff;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  stft_sample_scheduler_if #(.WORD_WIDTH(WW), .FFT_SIZE(FS)) bus ();

  stft_sample_scheduler #(
    .WORD_WIDTH  (WW),
    .FFT_SIZE    (FS),
    .DISP_PERIOD (DP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // External ring buffer: synchronous write, one-cycle read latency, garbage until written.
  logic [WW-1:0] ram [FS] = '{default: 16'hDEAD};
  always @(posedge clk) begin
    if (bus.rb_wr_en) ram[bus.rb_addr] <= bus.rb_wdata;
    if (bus.rb_rd_en) bus.rb_rdata <= ram[bus.rb_addr];
  end

  // Engine: eng_done pulses 4 cycles after eng_start.
  int eng_cnt = 0;
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      eng_cnt      = 0;
      bus.eng_done = 1'b0;
    end else begin
      bus.eng_done = 1'b0;
      if (eng_cnt != 0) begin
        eng_cnt--;
        if (eng_cnt == 0) bus.eng_done = 1'b1;
      end
      if (bus.eng_start) eng_cnt = 4;
    end
  end

  int cyc       = 0;
  int start_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.eng_start) start_cnt <= start_cnt + 1;
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  exp_t          exp_q [$];
  logic [WW-1:0] ref_mem [FS] = '{default: '0};
  int            m_ptr = 0, m_fill = 0, m_disp = 0;
  int            exp_starts = 0, t_start = 0, n_sample = 0;
  bit            hold_ok;
  logic [WW-1:0] wrap_seq [10] = '{16'h7FFF, 16'h0001, 16'h0011, 16'h0012, 16'h0013,
                                   16'h0014, 16'h0015, 16'h0016, 16'h8000, 16'h0000};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, 32'({bus.s_ready, bus.busy, bus.rb_rd_en, bus.rb_wr_en,
                              bus.eng_start, bus.disp_req, bus.overrun}), 32'(7'b1000000));
    check({tag, "_data"}, 32'({bus.rb_addr, bus.rb_wdata, bus.eng_diff}), 32'd0);
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset(tag);
    @(negedge clk);
    reset  = 1'b0;
    m_ptr  = 0;
    m_fill = 0;
    m_disp = 0;
    exp_q.delete();
  endtask

  // Drives one sample from IDLE and checks the RD, WR and START cycles; returns in START.
  task automatic start_sample(input logic [WW-1:0] val);
    exp_t          e, got;
    bit            ok = 1'b0;
    logic [WW-1:0] old;
    string         tag;
    n_sample++;
    tag = $sformatf("s%0d", n_sample);
    for (int i = 0; i < 50; i++) begin
      if (bus.s_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check({tag, "_ready"}, 32'(ok), 32'd1);
    old     = (m_fill < FS) ? '0 : ref_mem[m_ptr];
    e.addr  = AW'(m_ptr);
    e.wdata = val;
    e.diff  = val - old;
    exp_q.push_back(e);
    ref_mem[m_ptr] = val;
    exp_starts++;
    bus.s_valid = 1'b1;
    bus.s_data  = val;
    @(negedge clk);
    bus.s_valid = 1'b0;
    got = exp_q.pop_front();
    check({tag, "_rd"}, 32'({bus.rb_rd_en, bus.rb_wr_en, bus.eng_start, bus.rb_addr}),
          32'({1'b1, 1'b0, 1'b0, got.addr}));
    @(negedge clk);
    check({tag, "_wr"}, 32'({bus.rb_rd_en, bus.rb_wr_en, bus.eng_start, bus.rb_addr, bus.rb_wdata}),
          32'({1'b0, 1'b1, 1'b0, got.addr, got.wdata}));
    @(negedge clk);
    check({tag, "_diff"}, 32'({bus.eng_start, bus.eng_diff}), 32'({1'b1, got.diff}));
    t_start = cyc;
  endtask

  // Waits out the engine pass and checks the return to IDLE or the display request.
  task automatic finish_pass(input bit auto_ack);
    bit    ok = 1'b0;
    bit    exp_disp;
    string tag = $sformatf("s%0d", n_sample);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.s_ready || bus.disp_req) begin ok = 1'b1; break; end
    end
    check({tag, "_end"}, 32'(ok), 32'd1);
    check({tag, "_len"}, 32'(cyc - t_start), 32'd5);
    check({tag, "_starts"}, 32'(start_cnt), 32'(exp_starts));
    m_ptr = (m_ptr + 1) % FS;
    if (m_fill < FS) m_fill++;
    exp_disp = (m_disp == DP - 1);
    m_disp   = exp_disp ? 0 : m_disp + 1;
    check({tag, "_disp"}, 32'({bus.disp_req, bus.s_ready}), exp_disp ? 32'd2 : 32'd1);
    if (exp_disp && auto_ack) begin
      bus.disp_ack = 1'b1;
      @(negedge clk);
      bus.disp_ack = 1'b0;
      check({tag, "_ack"}, 32'({bus.disp_req, bus.s_ready, bus.busy}), 32'(3'b010));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.disp_ack = 1'b0;
    bus.ovr_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    // First sample after reset: warm-up ignores the 0xDEAD read data.
    start_sample(16'h0010);
    finish_pass(1'b1);

    // Fill 1..8, then wrap to address 0 with a real old sample.
    async_reset("rst_idle");
    for (int v = 1; v <= 8; v++) begin
      start_sample(WW'(v));
      finish_pass(1'b1);
    end
    start_sample(16'h0005);
    finish_pass(1'b1);

    // Modulo differences: 0x8000-0x7FFF and 0x0000-0x0001.
    for (int i = 0; i < 10; i++) begin
      start_sample(wrap_seq[i]);
      finish_pass(1'b1);
    end

    // Display handshake with a late acknowledge.
    async_reset("rst_disp_test");
    start_sample(16'h0101); finish_pass(1'b1);
    start_sample(16'h0102); finish_pass(1'b1);
    start_sample(16'h0103); finish_pass(1'b0);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hold_ok &= bus.disp_req & ~bus.s_ready & bus.busy;
    end
    check("disp_hold", 32'(hold_ok), 32'd1);
    bus.disp_ack = 1'b1;
    @(negedge clk);
    bus.disp_ack = 1'b0;
    check("disp_late_ack", 32'({bus.disp_req, bus.s_ready}), 32'(2'b01));
    bus.disp_ack = 1'b1;
    @(negedge clk);
    bus.disp_ack = 1'b0;
    check("stray_ack", 32'({bus.s_ready, bus.busy, bus.disp_req}), 32'(3'b100));
    start_sample(16'h0104); finish_pass(1'b1);
    start_sample(16'h0105); finish_pass(1'b1);
    start_sample(16'h0106); finish_pass(1'b1);

    // Overrun: drop in BUSY, then clear colliding with a drop, then a plain clear.
    start_sample(16'h0AAA);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h0BAD;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("ovr_set", 32'(bus.overrun), 32'd1);
    finish_pass(1'b1);
    start_sample(16'h0CCC);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.ovr_clr = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 32'd1);
    finish_pass(1'b1);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    check("ovr_clr", 32'(bus.overrun), 32'd0);

    // Reset mid-pass in BUSY, then in DISP; each restarts at address 0 in warm-up.
    start_sample(16'h0200);
    @(negedge clk);
    async_reset("rst_busy");
    start_sample(16'h0123);
    finish_pass(1'b1);
    start_sample(16'h0124); finish_pass(1'b1);
    start_sample(16'h0125); finish_pass(1'b0);
    async_reset("rst_disp");
    start_sample(16'h0456);
    finish_pass(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
